// File: rtl/hp_vpu_pkg.sv
// Shared types and decode helpers for the VPU dispatch slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hp_vpu_pkg;

    localparam logic [6:0] OPC_OPV    = 7'b1010111;
    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;

    typedef logic [4:0] vreg_idx_t;

    // Which vector-register fields an instruction touches.
    typedef struct packed {
        logic wr;       // writes vd
        logic rd_vd;    // reads the vd field (store data, vs3)
        logic rd_vs1;
        logic rd_vs2;
    } vreg_use_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } disp_state_t;

    function automatic vreg_use_t vreg_use(input logic [31:0] instr);
        vreg_use_t u;
        u = '0;
        case (instr[6:0])
            OPC_OPV:    u = '{wr: 1'b1, rd_vd: 1'b0, rd_vs1: 1'b1, rd_vs2: 1'b1};
            OPC_VSTORE: u = '{wr: 1'b0, rd_vd: 1'b1, rd_vs1: 1'b0, rd_vs2: 1'b1};
            OPC_VLOAD:  u = '{wr: 1'b1, rd_vd: 1'b0, rd_vs1: 1'b0, rd_vs2: 1'b1};
            default:    u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/hp_vpu_sb.sv
// 32-entry pending-write scoreboard with a 3-port hazard query.
// Latency: set/clear visible on the query one cycle later (no bypass).
// Backpressure: none; set, clear and flush are accepted every cycle.
// Ports: set/set_idx mark a pending write, clr/clr_idx retire one,
//        flush wipes all; q*_en/q*_idx are the queries, hazard is their OR.
module hp_vpu_sb
    import hp_vpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      set,
    input  vreg_idx_t set_idx,
    input  logic      clr,
    input  vreg_idx_t clr_idx,
    input  logic      flush,
    input  logic      q0_en,
    input  vreg_idx_t q0_idx,
    input  logic      q1_en,
    input  vreg_idx_t q1_idx,
    input  logic      q2_en,
    input  vreg_idx_t q2_idx,
    output logic      hazard
);

    logic [31:0] pend;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    assign set_mask = set ? (32'd1 << set_idx) : 32'd0;
    assign clr_mask = clr ? (32'd1 << clr_idx) : 32'd0;

    // Clear is applied before set so a same-bit collision leaves the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (flush) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_mask) | set_mask;
        end
    end

    assign hazard = (q0_en && pend[q0_idx]) ||
                    (q1_en && pend[q1_idx]) ||
                    (q2_en && pend[q2_idx]);

endmodule

// File: rtl/hp_vpu_dispatch.sv
// In-order dispatch from the VPU instruction queue to the execution pipeline.
// Latency: head popped combinationally, presented on the issue slot next cycle.
// Backpressure: holds the slot while iss_ready_i=0; stalls on hazard or inflight cap.
// Ports: iq_* queue head and pop; iss_* registered valid/ready issue slot;
//        wb_* writeback retire; flush_i starts a queue drain; busy_o, stall_cnt_o status.
module hp_vpu_dispatch
    import hp_vpu_pkg::*;
#(
    parameter int ID_W         = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iq_empty_i,
    input  logic [31:0]       iq_instr_i,
    input  logic [ID_W-1:0]   iq_id_i,
    input  logic [31:0]       iq_rs1_i,
    input  logic [31:0]       iq_rs2_i,
    output logic              iq_pop_o,
    output logic              iss_valid_o,
    input  logic              iss_ready_i,
    output logic [31:0]       iss_instr_o,
    output logic [ID_W-1:0]   iss_id_o,
    output logic [31:0]       iss_rs1_o,
    output logic [31:0]       iss_rs2_o,
    input  logic              wb_valid_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_vd_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

    disp_state_t state, state_nxt;
    logic [3:0]  inflight;
    vreg_use_t   use_h;
    logic        hazard;
    logic        slot_free;
    logic        can_issue;
    logic        wb_retire;

    assign use_h = vreg_use(iq_instr_i);

    hp_vpu_sb u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set     (can_issue && use_h.wr),
        .set_idx (iq_instr_i[11:7]),
        .clr     (wb_valid_i && wb_we_i),
        .clr_idx (wb_vd_i),
        .flush   (flush_i),
        .q0_en   (use_h.wr || use_h.rd_vd),
        .q0_idx  (iq_instr_i[11:7]),
        .q1_en   (use_h.rd_vs1),
        .q1_idx  (iq_instr_i[19:15]),
        .q2_en   (use_h.rd_vs2),
        .q2_idx  (iq_instr_i[24:20]),
        .hazard  (hazard)
    );

    assign slot_free = !iss_valid_o || iss_ready_i;
    assign can_issue = (state == ST_RUN) && !iq_empty_i && !hazard && slot_free &&
                       (inflight < MAX_IF) && !flush_i;
    assign iq_pop_o  = can_issue || ((state == ST_DRAIN) && !iq_empty_i);
    assign busy_o    = (inflight != 4'd0) || iss_valid_o || (state == ST_DRAIN);

    // A writeback with nothing in flight is spurious and must not underflow.
    assign wb_retire = wb_valid_i && (inflight != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush seen while draining simply keeps us in DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (flush_i) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!flush_i && iq_empty_i) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_o <= 1'b0;
            iss_instr_o <= '0;
            iss_id_o    <= '0;
            iss_rs1_o   <= '0;
            iss_rs2_o   <= '0;
        end else if (flush_i) begin
            iss_valid_o <= 1'b0;
        end else if (can_issue) begin
            iss_valid_o <= 1'b1;
            iss_instr_o <= iq_instr_i;
            iss_id_o    <= iq_id_i;
            iss_rs1_o   <= iq_rs1_i;
            iss_rs2_o   <= iq_rs2_i;
        end else if (iss_ready_i) begin
            iss_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 4'd0;
        end else if (flush_i) begin
            inflight <= 4'd0;
        end else if (can_issue && !wb_retire) begin
            inflight <= inflight + 4'd1;
        end else if (!can_issue && wb_retire) begin
            inflight <= inflight - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            stall_cnt_o <= '0;
        end else if ((state == ST_RUN) && !iq_empty_i && !iq_pop_o &&
                     (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hp_vpu_dispatch.sv
module tb_hp_vpu_dispatch;

    localparam int ID_W         = 4;
    localparam int MAX_INFLIGHT = 4;
    localparam int CNT_W        = 32;

    localparam logic [6:0] OP_V  = 7'b1010111;
    localparam logic [6:0] OP_LD = 7'b0000111;
    localparam logic [6:0] OP_ST = 7'b0100111;
    localparam logic [6:0] OP_X  = 7'b0110011;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             iq_empty = 1'b1;
    logic [31:0]      iq_instr = '0;
    logic [ID_W-1:0]  iq_id = '0;
    logic [31:0]      iq_rs1 = '0;
    logic [31:0]      iq_rs2 = '0;
    logic             iq_pop;
    logic             iss_valid;
    logic             iss_ready = 1'b0;
    logic [31:0]      iss_instr;
    logic [ID_W-1:0]  iss_id;
    logic [31:0]      iss_rs1;
    logic [31:0]      iss_rs2;
    logic             wb_valid = 1'b0;
    logic             wb_we = 1'b0;
    logic [4:0]       wb_vd = '0;
    logic             flush = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hp_vpu_dispatch #(.ID_W(ID_W), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .iq_empty_i(iq_empty), .iq_instr_i(iq_instr), .iq_id_i(iq_id),
        .iq_rs1_i(iq_rs1), .iq_rs2_i(iq_rs2), .iq_pop_o(iq_pop),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_instr_o(iss_instr),
        .iss_id_o(iss_id), .iss_rs1_o(iss_rs1), .iss_rs2_o(iss_rs2),
        .wb_valid_i(wb_valid), .wb_we_i(wb_we), .wb_vd_i(wb_vd),
        .flush_i(flush), .busy_o(busy), .stall_cnt_o(stall_cnt)
    );

    int checks = 0;
    int errors = 0;
    int npops  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue contents seen by the DUT
    typedef struct {
        logic [31:0]     instr;
        logic [ID_W-1:0] id;
        logic [31:0]     rs1;
        logic [31:0]     rs2;
    } ent_t;
    ent_t q[$];
    logic [ID_W-1:0] next_id = '0;

    // Reference model state
    bit [31:0]       m_sb;
    bit              m_if_we[$];
    bit [4:0]        m_if_vd[$];
    bit              m_slot_v;
    ent_t            m_slot;
    bit              m_drain;
    longint unsigned m_stall;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] vd,
                                       input logic [4:0] vs1, input logic [4:0] vs2);
        return {7'd0, vs2, vs1, 3'd0, vd, opc};
    endfunction

    task automatic use_of(input logic [31:0] ins, output bit wr, output bit rvd,
                          output bit r1, output bit r2);
        wr = 0; rvd = 0; r1 = 0; r2 = 0;
        if (ins[6:0] == OP_V)       begin wr = 1; r1 = 1; r2 = 1; end
        else if (ins[6:0] == OP_ST) begin rvd = 1; r2 = 1; end
        else if (ins[6:0] == OP_LD) begin wr = 1; r2 = 1; end
    endtask

    task automatic push(input logic [31:0] ins);
        ent_t e;
        e.instr = ins; e.id = next_id; e.rs1 = $urandom; e.rs2 = $urandom;
        q.push_back(e);
        next_id = next_id + 1'b1;
    endtask

    task automatic drive_head();
        if (q.size() > 0) begin
            iq_empty = 1'b0; iq_instr = q[0].instr; iq_id = q[0].id;
            iq_rs1 = q[0].rs1; iq_rs2 = q[0].rs2;
        end else begin
            iq_empty = 1'b1; iq_instr = '0; iq_id = '0; iq_rs1 = '0; iq_rs2 = '0;
        end
    endtask

    // One clock: drive inputs, compare against the model at negedge, advance the model.
    task automatic step(input logic rdy, input logic wv, input logic we,
                        input logic [4:0] vd, input logic fl);
        bit wr, rvd, r1, r2, haz, cani, pop, run;
        ent_t h;
        iss_ready = rdy; wb_valid = wv; wb_we = we; wb_vd = vd; flush = fl;
        drive_head();
        @(negedge clk);
        cani = 0;
        if (q.size() > 0) begin
            h = q[0];
            use_of(h.instr, wr, rvd, r1, r2);
            haz = ((wr || rvd) && m_sb[h.instr[11:7]]) || (r1 && m_sb[h.instr[19:15]]) ||
                  (r2 && m_sb[h.instr[24:20]]);
            cani = !m_drain && !haz && (!m_slot_v || rdy) &&
                   (m_if_vd.size() < MAX_INFLIGHT) && !fl;
        end
        pop = cani || (m_drain && q.size() > 0);
        run = !m_drain;
        chk("iq_pop", iq_pop, pop);
        chk("iss_valid", iss_valid, m_slot_v);
        if (m_slot_v) begin
            chk("iss_instr", iss_instr, m_slot.instr);
            chk("iss_id", iss_id, m_slot.id);
            chk("iss_rs1", iss_rs1, m_slot.rs1);
            chk("iss_rs2", iss_rs2, m_slot.rs2);
        end
        chk("busy", busy, (m_if_vd.size() > 0) || m_slot_v || m_drain);
        chk("stall_cnt", stall_cnt, m_stall);
        if (iq_pop === 1'b1) npops++;
        if (fl) begin
            m_drain = 1; m_slot_v = 0; m_sb = '0; m_stall = 0;
            m_if_vd.delete(); m_if_we.delete();
        end else begin
            if (run && q.size() > 0 && !pop && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (wv && we) m_sb[vd] = 1'b0;
            if (wv && m_if_vd.size() > 0) begin
                void'(m_if_vd.pop_front()); void'(m_if_we.pop_front());
            end
            if (cani) begin
                if (wr) m_sb[h.instr[11:7]] = 1'b1;
                m_if_vd.push_back(h.instr[11:7]); m_if_we.push_back(wr);
                m_slot_v = 1; m_slot = h;
            end else if (rdy) begin
                m_slot_v = 0;
            end
            if (m_drain && q.size() == 0) m_drain = 0;
        end
        if (pop) void'(q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic step_wb_oldest(input logic rdy);
        if (m_if_vd.size() > 0) step(rdy, 1'b1, m_if_we[0], m_if_vd[0], 1'b0);
        else                    step(rdy, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic settle();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (q.size() == 0 && !m_slot_v && m_if_vd.size() == 0 && !m_drain) done = 1;
            else step_wb_oldest(1'b1);
        end
        chk("settle_timeout", done, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iss_ready = 0; wb_valid = 0; wb_we = 0; wb_vd = 0; flush = 0;
        q.delete(); drive_head();
        next_id = '0;
        #2;
        chk("rst_iss_valid", iss_valid, 1'b0);
        chk("rst_iss_instr", iss_instr, 32'd0);
        chk("rst_iss_id", iss_id, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_pop", iq_pop, 1'b0);
        m_sb = '0; m_if_vd.delete(); m_if_we.delete(); m_slot_v = 0;
        m_drain = 0; m_stall = 0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic rand_step();
        logic rdy, wv, we, fl;
        logic [4:0] vd;
        rdy = ($urandom_range(0, 9) < 7);
        wv = 0; we = 0; vd = '0;
        if (m_if_vd.size() > 0 && $urandom_range(0, 9) < 4) begin
            wv = 1; we = m_if_we[0]; vd = m_if_vd[0];
        end else if (m_if_vd.size() == 0 && $urandom_range(0, 19) == 0) begin
            wv = 1; we = 0; vd = 5'($urandom_range(0, 31));
        end
        fl = ($urandom_range(0, 99) == 0);
        step(rdy, wv, we, vd, fl);
    endtask

    initial begin
        logic [6:0] opcs [4];
        opcs[0] = OP_V; opcs[1] = OP_LD; opcs[2] = OP_ST; opcs[3] = OP_X;

        // Independent stream
        do_reset();
        for (int k = 1; k <= 3; k++) push(mk(OP_V, 5'(k), 5'd10, 5'd11));
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0);
            chk("t1_valid", iss_valid, 1'b1);
            chk("t1_id", iss_id, k);
        end
        chk("t1_stall", stall_cnt, 0);
        settle();

        // RAW stall cleared one cycle after writeback
        do_reset();
        push(mk(OP_V, 5'd4, 5'd10, 5'd11));
        push(mk(OP_V, 5'd5, 5'd4, 5'd12));
        step(1, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        chk("t2_stall_held", stall_cnt, 3);
        step(1, 1, 1, 5'd4, 0);
        chk("t2_stall_wb", stall_cnt, 4);
        chk("t2_pop_after_wb", iq_pop, 1'b1);
        step(1, 0, 0, 0, 0);
        chk("t2_valid", iss_valid, 1'b1);
        chk("t2_id", iss_id, 1);
        settle();

        // Backpressure
        do_reset();
        push(mk(OP_V, 5'd6, 5'd10, 5'd11));
        push(mk(OP_V, 5'd7, 5'd10, 5'd11));
        npops = 0;
        repeat (5) step(0, 0, 0, 0, 0);
        chk("t3_pops_held", npops, 1);
        chk("t3_id_held", iss_id, 0);
        chk("t3_stall", stall_cnt, 4);
        step(1, 0, 0, 0, 0);
        chk("t3_pops", npops, 2);
        chk("t3_id", iss_id, 1);
        settle();

        // Inflight cap
        do_reset();
        for (int k = 1; k <= 6; k++) push(mk(OP_V, 5'(k), 5'd20, 5'd21));
        npops = 0;
        repeat (8) step(1, 0, 0, 0, 0);
        chk("t4_capped", npops, 4);
        step(1, 1, 1, 5'd1, 0);
        chk("t4_wb_cycle", npops, 4);
        step(1, 0, 0, 0, 0);
        chk("t4_fifth", npops, 5);
        settle();

        // Flush with queue drain
        do_reset();
        push(mk(OP_V, 5'd1, 5'd10, 5'd11));
        push(mk(OP_V, 5'd2, 5'd10, 5'd11));
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 3; k <= 5; k++) push(mk(OP_V, 5'(k), 5'd1, 5'd2));
        npops = 0;
        step(1, 0, 0, 0, 1);
        chk("t5_valid_clr", iss_valid, 1'b0);
        chk("t5_busy_drain", busy, 1'b1);
        repeat (3) step(1, 0, 0, 0, 0);
        chk("t5_drained", npops, 3);
        chk("t5_busy_last", busy, 1'b1);
        step(1, 0, 0, 0, 0);
        chk("t5_idle", busy, 1'b0);
        push(mk(OP_V, 5'd6, 5'd1, 5'd2));
        drive_head();
        #1;
        chk("t5_raw_old_vd", iq_pop, 1'b1);
        settle();

        // Store after load on the same register
        do_reset();
        push(mk(OP_LD, 5'd8, 5'd0, 5'd9));
        push(mk(OP_ST, 5'd8, 5'd0, 5'd10));
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t6_store_held", iq_pop, 1'b0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 5'd8, 0);
        chk("t6_pop_after_wb", iq_pop, 1'b1);
        step(1, 0, 0, 0, 0);
        chk("t6_id", iss_id, 1);
        push(mk(OP_V, 5'd8, 5'd0, 5'd0));
        drive_head();
        #1;
        chk("t6_store_no_sb", iq_pop, 1'b1);
        settle();

        // Randomized traffic with a mid-run asynchronous reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            if (q.size() < 8 && $urandom_range(0, 1) == 1)
                push(mk(opcs[$urandom_range(0, 3)], 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
            rand_step();
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hp_vpu_dispatch.md
Name: hp_vpu_dispatch

Overview:
- In-order dispatch controller between the VPU instruction queue and the execution pipeline.
- Pops the queue head when it is free of vector-register hazards and the pipeline can accept it, then presents it on a registered valid/ready issue port.
- Keeps a 32-entry pending-write scoreboard and an in-flight counter; clears them from writeback; supports flush with queue drain.

Parameters:
- ID_W, 4, instruction ID width; must match the queue.
- MAX_INFLIGHT, 4, maximum issued-but-not-written-back instructions (1..15).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- iq_empty_i  in  1  queue empty; head fields are valid when 0
- iq_instr_i  in  32  queue head instruction
- iq_id_i  in  ID_W  queue head ID
- iq_rs1_i  in  32  queue head scalar rs1
- iq_rs2_i  in  32  queue head scalar rs2
- iq_pop_o  out  1  pop queue head this cycle (combinational)
- iss_valid_o  out  1  issue slot valid (registered)
- iss_ready_i  in  1  pipeline accepts the issue slot
- iss_instr_o  out  32  issued instruction
- iss_id_o  out  ID_W  issued ID
- iss_rs1_o  out  32  issued rs1
- iss_rs2_o  out  32  issued rs2
- wb_valid_i  in  1  one instruction completes this cycle
- wb_we_i  in  1  completing instruction wrote a vreg
- wb_vd_i  in  5  vreg written
- flush_i  in  1  flush request (1-cycle pulse)
- busy_o  out  1  any in-flight, slot valid, or draining
- stall_cnt_o  out  CNT_W  cycles the queue was non-empty and not popped (RUN only), saturating

Behaviour:
- Reset: all outputs 0; scoreboard 0; inflight 0; state RUN.
- Decode from the head: vd=[11:7], vs1=[19:15], vs2=[24:20].
  - OP-V (opcode 7'b1010111): writes vd; reads vs1, vs2.
  - Store (7'b0100111): no write; reads vd (as vs3), vs2.
  - Load (7'b0000111): writes vd; reads vs2.
  - Any other opcode: no vreg access.
- Hazard: a register that is read or written by the head has its scoreboard bit set. The check uses the registered scoreboard; there is no writeback bypass, so a stall clears one cycle after the wb.
- slot_free = !iss_valid_o || iss_ready_i.
- can_issue = state==RUN && !iq_empty_i && !hazard && slot_free && inflight<MAX_INFLIGHT && !flush_i.
- iq_pop_o = can_issue || (state==DRAIN && !iq_empty_i).
- Issue slot:
  - On can_issue: the slot registers the head fields; iss_valid_o=1 next cycle.
  - On iss_ready_i without can_issue: iss_valid_o clears.
  - While valid and not ready: fields stay stable.
  - Back-to-back issue reaches full throughput (1 per cycle).
- Scoreboard:
  - On can_issue with a writing opcode: set bit vd.
  - On wb_valid_i&&wb_we_i: clear bit wb_vd_i.
  - Set and clear of the same bit in one cycle cannot occur (WAW stalls); if it does, set wins.
- Inflight:
  - +1 on can_issue, -1 on wb_valid_i; both in one cycle leaves it unchanged.
  - wb_valid_i at inflight==0 is ignored.
- FSM:
  - RUN -> DRAIN on flush_i.
  - DRAIN: pop every cycle while !iq_empty_i; go to RUN on the first cycle with iq_empty_i=1.
  - Flush cycle: iss_valid_o clears next cycle; scoreboard, inflight and stall_cnt_o clear; wb_valid_i in the flush cycle is ignored.
  - flush_i during DRAIN restarts DRAIN (no other effect).
- Async reset mid-operation returns to the reset state immediately.

Decomposition:
- hp_vpu_pkg additions: OPC_OPV, OPC_VLOAD, OPC_VSTORE constants; vreg_idx_t (logic [4:0]); function vreg_use(instr) returning {wr, rd_vd, rd_vs1, rd_vs2}.
- Sub-module hp_vpu_sb: 32-bit scoreboard with set/clear/flush and a 3-read hazard query.

Test Plan:
- Independent stream: OP-V vd=1,2,3 pushed, ready=1 -> iss_valid_o high 3 consecutive cycles, IDs 0,1,2; stall_cnt_o=0.
- RAW: vadd vd=4, then vs1=4 -> second held; wb_valid_i/we/vd=4 at cycle t -> second popped t+1, issued t+2; stall_cnt_o counts the held cycles.
- Backpressure: iss_ready_i=0 for 5 cycles with 2 queued -> fields stable, one pop only; ready=1 -> second issues next cycle.
- Inflight cap: MAX_INFLIGHT=4, 6 independent ops, no wb -> exactly 4 issued; one wb -> 5th issues.
- Flush: 3 queued, 2 in flight, flush_i -> iss_valid_o=0 next cycle, 3 pops over 3 cycles, busy_o=0 after queue empty, scoreboard clear (RAW on old vd issues immediately).
- Store hazard: store vs3=8 after load vd=8 -> store stalls until wb vd=8; store issue sets no scoreboard bit.
